// File: rtl/mvm_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_uart_pkg
//  Description : Shared geometry, derived bus widths, element/vector typedefs
//                and FSM state encodings for the UART-attached matrix-vector
//                multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
package mvm_uart_pkg;

  localparam int BITS_PER_WORD = 8;
  localparam int R             = 8;
  localparam int C             = 8;
  localparam int W_X           = 4;
  localparam int W_K           = 3;
  localparam int W_Y_OUT       = 32;

  localparam int W_BUS_KX     = R*C*W_K + C*W_X;
  localparam int W_BUS_Y      = R*W_Y_OUT;
  localparam int W_Y          = W_X + W_K + $clog2(C);
  localparam int NUM_WORDS_RX = (W_BUS_KX + BITS_PER_WORD - 1) / BITS_PER_WORD;
  localparam int NUM_WORDS_TX = (W_BUS_Y + BITS_PER_WORD - 1) / BITS_PER_WORD;

  // Packed row-major layouts: element [r][c] sits at bit (r*C+c)*W_K.
  typedef logic [W_K-1:0]                k_elem_t;
  typedef k_elem_t [R-1:0][C-1:0]        k_mat_t;
  typedef logic [W_X-1:0]                x_elem_t;
  typedef x_elem_t [C-1:0]               x_vec_t;
  typedef logic [R-1:0][W_Y_OUT-1:0]     y_vec_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/mvm_uart_axis_mvm.sv
`default_nettype none
// ============================================================================
//  Module      : axis_mvm
//  Description : Signed matrix-vector multiply y = K*x behind AXI-Stream
//                handshakes. Result is registered and held until accepted.
//  Ports       : clk, rst                      clock / sync active-high reset
//                s_axis_kx_tvalid/tready/tdata packed K matrix + x vector in
//                m_axis_y_tvalid/tready/tdata  packed sign-extended y out
//  Revision    : 1.0  initial release
// ============================================================================
module axis_mvm
  import mvm_uart_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axis_kx_tvalid,
  output logic                s_axis_kx_tready,
  input  logic [W_BUS_KX-1:0] s_axis_kx_tdata,
  output logic                m_axis_y_tvalid,
  input  logic                m_axis_y_tready,
  output logic [W_BUS_Y-1:0]  m_axis_y_tdata
);

  localparam int W_P = W_K + W_X;

  k_mat_t                  w_k;
  x_vec_t                  w_x;
  logic [R-1:0][W_Y-1:0]   w_y;
  logic                    w_ready;
  logic                    r_valid;
  y_vec_t                  r_y;

  assign w_k = s_axis_kx_tdata[R*C*W_K-1:0];
  assign w_x = s_axis_kx_tdata[W_BUS_KX-1:R*C*W_K];

  // Output register may be overwritten when empty or being drained this cycle.
  assign w_ready          = !r_valid || m_axis_y_tready;
  assign s_axis_kx_tready = w_ready;
  assign m_axis_y_tvalid  = r_valid;
  assign m_axis_y_tdata   = r_y;

  // Operands are sign-extended to the product width, so the low W_P bits of
  // an unsigned multiply equal the signed product; then extended to W_Y.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      w_y[r] = '0;
      for (int c = 0; c < C; c++) begin
        logic [W_P-1:0] w_ke;
        logic [W_P-1:0] w_xe;
        logic [W_P-1:0] w_prod;
        w_ke   = {{(W_P-W_K){w_k[r][c][W_K-1]}}, w_k[r][c]};
        w_xe   = {{(W_P-W_X){w_x[c][W_X-1]}}, w_x[c]};
        w_prod = w_ke * w_xe;
        w_y[r] = w_y[r] + {{(W_Y-W_P){w_prod[W_P-1]}}, w_prod};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (s_axis_kx_tvalid && w_ready) begin
      r_valid <= 1'b1;
      for (int r = 0; r < R; r++) begin
        r_y[r] <= {{(W_Y_OUT-W_Y){w_y[r][W_Y-1]}}, w_y[r]};
      end
    end else if (m_axis_y_tready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mvm_uart_system.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with packet assembly. Bytes fill the kx
//                bus LSB-first; a full packet is presented on m_valid/m_data
//                and held until m_ready. Bytes arriving while held, and bytes
//                with a bad stop bit, are discarded.
//  Ports       : clk, rst, i_rx, m_valid, m_ready, m_data
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 868
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rx,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [W_BUS_KX-1:0] m_data
);

  localparam int W_CNT = $clog2(CLOCKS_PER_PULSE) + 1;
  localparam int W_BIT = $clog2(BITS_PER_WORD);
  localparam int W_IDX = $clog2(NUM_WORDS_RX);
  localparam int W_BUF = NUM_WORDS_RX * BITS_PER_WORD;

  localparam logic [W_CNT-1:0] c_full      = W_CNT'(CLOCKS_PER_PULSE - 1);
  localparam logic [W_CNT-1:0] c_half      = W_CNT'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [W_BIT-1:0] c_last_bit  = W_BIT'(BITS_PER_WORD - 1);
  localparam logic [W_IDX-1:0] c_last_word = W_IDX'(NUM_WORDS_RX - 1);

  rx_state_e                r_state;
  logic [1:0]               r_sync;
  logic [W_CNT-1:0]         r_cnt;
  logic [W_BIT-1:0]         r_bit;
  logic [BITS_PER_WORD-1:0] r_shift;
  logic [W_IDX-1:0]         r_word;
  logic [W_BUF-1:0]         r_buf;
  logic                     r_valid;
  logic                     w_rx;

  // Two-flop synchronizer: rx comes straight from a board pin.
  assign w_rx    = r_sync[1];
  assign m_valid = r_valid;
  assign m_data  = r_buf[W_BUS_KX-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) begin
            r_state <= RX_START;
          end
        end
        RX_START: begin
          // Re-check mid start bit; a high line here was a glitch.
          if (r_cnt == c_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == c_full) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[BITS_PER_WORD-1:1]};
            if (r_bit == c_last_bit) begin
              r_state <= RX_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == c_full) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            // Keep the byte only with a valid stop bit and no packet pending.
            if (w_rx && !r_valid) begin
              r_buf[r_word*BITS_PER_WORD +: BITS_PER_WORD] <= r_shift;
              if (r_word == c_last_word) begin
                r_word  <= '0;
                r_valid <= 1'b1;
              end else begin
                r_word <= r_word + 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// ============================================================================
//  Module      : uart_tx
//  Description : Serialises a latched y bus as back-to-back UART frames
//                (start, 8 data LSB first, 2 stop bits). Ready only when idle.
//  Ports       : clk, rst, s_valid, s_ready, s_data, o_tx
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 868
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W_BUS_Y-1:0] s_data,
  output logic               o_tx
);

  localparam int W_CNT   = $clog2(CLOCKS_PER_PULSE) + 1;
  localparam int W_FRAME = BITS_PER_WORD + 3;
  localparam int W_BIT   = $clog2(W_FRAME);
  localparam int W_IDX   = $clog2(NUM_WORDS_TX);
  localparam int W_BUF   = NUM_WORDS_TX * BITS_PER_WORD;

  localparam logic [W_CNT-1:0] c_full       = W_CNT'(CLOCKS_PER_PULSE - 1);
  localparam logic [W_BIT-1:0] c_last_fbit  = W_BIT'(W_FRAME - 1);
  localparam logic [W_IDX-1:0] c_last_word  = W_IDX'(NUM_WORDS_TX - 1);

  tx_state_e          r_state;
  logic [W_CNT-1:0]   r_cnt;
  logic [W_BIT-1:0]   r_bit;
  logic [W_IDX-1:0]   r_word;
  logic [W_FRAME-1:0] r_frame;
  logic [W_BUF-1:0]   r_buf;
  logic               r_ready;
  logic               r_tx;
  logic [W_BUF-1:0]   w_pad;

  assign w_pad   = W_BUF'(s_data);
  assign s_ready = r_ready;
  assign o_tx    = r_tx;

  // r_frame[0] is always the bit currently on the line; r_buf holds the
  // bytes still to be framed, next one in the low byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_ready <= 1'b1;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (s_valid && r_ready) begin
            r_frame <= {2'b11, w_pad[BITS_PER_WORD-1:0], 1'b0};
            r_buf   <= w_pad >> BITS_PER_WORD;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_word  <= '0;
            r_ready <= 1'b0;
            r_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (r_cnt == c_full) begin
            r_cnt <= '0;
            if (r_bit == c_last_fbit) begin
              if (r_word == c_last_word) begin
                r_state <= TX_IDLE;
                r_ready <= 1'b1;
                r_tx    <= 1'b1;
              end else begin
                r_word  <= r_word + 1'b1;
                r_frame <= {2'b11, r_buf[BITS_PER_WORD-1:0], 1'b0};
                r_buf   <= r_buf >> BITS_PER_WORD;
                r_tx    <= 1'b0;
                r_bit   <= '0;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_frame <= r_frame >> 1;
              r_tx    <= r_frame[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// ============================================================================
//  Module      : mvm_uart_system
//  Description : UART-attached matrix-vector multiplier. Receives packed K
//                and x over rx, computes y = K*x, returns packed y over tx.
//  Ports       : clk   system clock
//                rstn  synchronous reset, active HIGH despite the name
//                rx    UART serial input (idle high)
//                tx    UART serial output (idle high)
//  Revision    : 1.0  initial release
// ============================================================================
module mvm_uart_system
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 868
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx
);

  logic                w_kx_valid;
  logic                w_kx_ready;
  logic [W_BUS_KX-1:0] w_kx_data;
  logic                w_y_valid;
  logic                w_y_ready;
  logic [W_BUS_Y-1:0]  w_y_data;

  uart_rx #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
  ) UART_RX (
    .clk     (clk),
    .rst     (rstn),
    .i_rx    (rx),
    .m_valid (w_kx_valid),
    .m_ready (w_kx_ready),
    .m_data  (w_kx_data)
  );

  axis_mvm AXIS_MVM (
    .clk              (clk),
    .rst              (rstn),
    .s_axis_kx_tvalid (w_kx_valid),
    .s_axis_kx_tready (w_kx_ready),
    .s_axis_kx_tdata  (w_kx_data),
    .m_axis_y_tvalid  (w_y_valid),
    .m_axis_y_tready  (w_y_ready),
    .m_axis_y_tdata   (w_y_data)
  );

  uart_tx #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
  ) UART_TX (
    .clk     (clk),
    .rst     (rstn),
    .s_valid (w_y_valid),
    .s_ready (w_y_ready),
    .s_data  (w_y_data),
    .o_tx    (tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_mvm_uart_system.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_uart_system
//  Description : Self-checking bench for mvm_uart_system. Drives packets on
//                rx, decodes tx frames, compares against an integer model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mvm_uart_system;

  localparam int CPP = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic rx   = 1'b1;
  logic tx;

  mvm_uart_system #(.CLOCKS_PER_PULSE(CPP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frame_err = 0;
  int stab_err = 0;

  logic [7:0]  rxq[$];    // bytes decoded from tx
  logic [31:0] expq[$];   // expected y words, 8 per packet, in order
  logic [31:0] last_y[8];

  int km[8][8];
  int xv[8];

  // ---------------- tx line decoder (samples mid-bit on negedge) ----------
  int         m_busy = 0;
  int         m_cnt  = 0;
  logic [7:0] m_sh   = '0;
  always @(negedge clk) begin
    if (rstn) begin
      m_busy = 0;
    end else if (m_busy == 0) begin
      if (tx == 1'b0) begin
        m_busy = 1;
        m_cnt  = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt >= 6 && m_cnt <= 34 && (m_cnt % 4) == 2) begin
        m_sh = {tx, m_sh[7:1]};
      end else if (m_cnt == 38) begin
        if (tx !== 1'b1) frame_err++;
      end else if (m_cnt == 42) begin
        if (tx !== 1'b1) frame_err++;
        rxq.push_back(m_sh);
        m_busy = 0;
      end
    end
  end

  // ---------------- kx handshake stability watcher -----------------------
  logic         p_v = 1'b0, p_r = 1'b0, p_rst = 1'b1;
  logic [223:0] p_d = '0;
  always @(negedge clk) begin
    if (p_v && !p_r && !p_rst) begin
      if (!(dut.AXIS_MVM.s_axis_kx_tvalid === 1'b1 &&
            dut.AXIS_MVM.s_axis_kx_tdata === p_d)) stab_err++;
    end
    p_v   = dut.AXIS_MVM.s_axis_kx_tvalid;
    p_r   = dut.AXIS_MVM.s_axis_kx_tready;
    p_d   = dut.AXIS_MVM.s_axis_kx_tdata;
    p_rst = rstn;
  end

  // ---------------- helpers ----------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int sx(input int v, input int w);
    int t;
    t = v & ((1 << w) - 1);
    if (t >= (1 << (w - 1))) t -= (1 << w);
    return t;
  endfunction

  // Packs K/x into the byte stream image and queues the expected y words.
  task automatic prep_packet(output logic [223:0] bus);
    int s;
    bus = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bus[(r*8+c)*3 +: 3] = 3'(km[r][c]);
    for (int c = 0; c < 8; c++)
      bus[192 + c*4 +: 4] = 4'(xv[c]);
    for (int r = 0; r < 8; r++) begin
      s = 0;
      for (int c = 0; c < 8; c++) s += sx(km[r][c], 3) * sx(xv[c], 4);
      expq.push_back(32'(s));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    rx = 1'b0;
    tick(CPP);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPP);
    end
    rx = good;
    tick(CPP);
    rx = 1'b1;
    if (!good) tick(3*CPP);
  endtask

  task automatic send_bus(input logic [223:0] bus, input int bad_at);
    for (int i = 0; i < 28; i++) begin
      if (i == bad_at) send_byte(8'h5A, 1'b0);
      send_byte(bus[i*8 +: 8], 1'b1);
    end
  endtask

  task automatic send_packet();
    logic [223:0] bus;
    prep_packet(bus);
    send_bus(bus, -1);
  endtask

  task automatic rand_kx();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        km[r][c] = int'($urandom_range(0, 7)) - 4;
    for (int c = 0; c < 8; c++) xv[c] = int'($urandom_range(0, 15)) - 8;
  endtask

  task automatic check_result(input string tag);
    logic [31:0] got;
    logic [31:0] exp_w;
    for (int i = 0; i < 4000 && rxq.size() < 32; i++) tick(1);
    checks++;
    assert (rxq.size() >= 32) else begin
      errors++;
      $error("FAIL %s_bytes: observed %0d bytes, expected 32", tag, rxq.size());
    end
    for (int r = 0; r < 8; r++) begin
      exp_w = (expq.size() > 0) ? expq.pop_front() : 32'h0;
      if (rxq.size() >= 4) begin
        got = {rxq[3], rxq[2], rxq[1], rxq[0]};
        repeat (4) void'(rxq.pop_front());
        last_y[r] = got;
        checks++;
        assert (got === exp_w) else begin
          errors++;
          $error("FAIL %s_y%0d: observed %h expected %h", tag, r, got, exp_w);
        end
      end
    end
    rxq.delete();
  endtask

  // ---------------- directed sequence -------------------------------------
  initial begin
    logic [223:0] bus;
    int n;

    // Reset state
    tick(3);
    checks++; assert (tx === 1'b1) else begin errors++; $error("FAIL rst_tx: observed %b expected 1", tx); end
    checks++; assert (dut.UART_RX.m_valid === 1'b0) else begin errors++; $error("FAIL rst_kx_valid: observed %b expected 0", dut.UART_RX.m_valid); end
    checks++; assert (dut.AXIS_MVM.m_axis_y_tvalid === 1'b0) else begin errors++; $error("FAIL rst_y_valid: observed %b expected 0", dut.AXIS_MVM.m_axis_y_tvalid); end
    checks++; assert (dut.UART_TX.s_ready === 1'b1) else begin errors++; $error("FAIL rst_tx_ready: observed %b expected 1", dut.UART_TX.s_ready); end
    rstn = 1'b0;
    tick(2);

    // 1: identity K, x = 1..8
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) km[r][c] = (r == c) ? 1 : 0;
    for (int c = 0; c < 8; c++) xv[c] = c + 1;
    send_packet();
    check_result("ident");
    checks++; assert (last_y[0] === 32'h00000001) else begin errors++; $error("FAIL ident_y0_const: observed %h expected 00000001", last_y[0]); end
    checks++; assert (last_y[7] === 32'hFFFFFFF8) else begin errors++; $error("FAIL ident_y7_const: observed %h expected fffffff8", last_y[7]); end

    // 2: all 3 * all 7, then all -4 * all -8
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) km[r][c] = 3;
    for (int c = 0; c < 8; c++) xv[c] = 7;
    send_packet();
    check_result("k3x7");
    checks++; assert (last_y[3] === 32'h000000A8) else begin errors++; $error("FAIL k3x7_const: observed %h expected 000000a8", last_y[3]); end
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) km[r][c] = -4;
    for (int c = 0; c < 8; c++) xv[c] = -8;
    send_packet();
    check_result("kn4xn8");
    checks++; assert (last_y[5] === 32'h00000100) else begin errors++; $error("FAIL kn4xn8_const: observed %h expected 00000100", last_y[5]); end

    // Random packets
    for (int p = 0; p < 3; p++) begin
      rand_kx();
      send_packet();
      check_result("rand");
    end

    // 5: two packets back to back
    rand_kx();
    send_packet();
    rand_kx();
    send_packet();
    check_result("b2b_first");
    check_result("b2b_second");

    // 4: framing error mid-packet plus one trailing good byte
    rand_kx();
    prep_packet(bus);
    send_bus(bus, 10);
    send_byte(8'hFF, 1'b1);
    check_result("framing");
    tick(600);
    checks++; assert (rxq.size() == 0) else begin errors++; $error("FAIL framing_extra: observed %0d bytes expected 0", rxq.size()); end

    // 3: held reset discards the partial packet
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++; assert (tx === 1'b1) else begin errors++; $error("FAIL hold_rst_tx: observed %b expected 1", tx); end
      checks++; assert (dut.AXIS_MVM.m_axis_y_tvalid === 1'b0) else begin errors++; $error("FAIL hold_rst_yv: observed %b expected 0", dut.AXIS_MVM.m_axis_y_tvalid); end
    end
    rstn = 1'b0;
    tick(2);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) km[r][c] = (r == c) ? 1 : 0;
    for (int c = 0; c < 8; c++) xv[c] = c + 1;
    send_packet();
    check_result("after_rst");

    // 6: reset during byte 10 of tx
    rand_kx();
    send_packet();
    for (int i = 0; i < 3000 && rxq.size() < 10; i++) tick(1);
    checks++; assert (rxq.size() >= 10) else begin errors++; $error("FAIL midtx_wait: observed %0d bytes expected 10", rxq.size()); end
    tick(8);
    rstn = 1'b1;
    tick(1);
    checks++; assert (tx === 1'b1) else begin errors++; $error("FAIL midtx_rst_tx: observed %b expected 1", tx); end
    rstn = 1'b0;
    repeat (8) void'(expq.pop_front());
    n = rxq.size();
    tick(800);
    checks++; assert (rxq.size() == n) else begin errors++; $error("FAIL midtx_no_more: observed %0d bytes expected %0d", rxq.size(), n); end
    rxq.delete();
    rand_kx();
    send_packet();
    check_result("post_midtx");

    // Line-level integrity
    checks++; assert (frame_err == 0) else begin errors++; $error("FAIL tx_stop_bits: observed %0d bad stops expected 0", frame_err); end
    checks++; assert (stab_err == 0) else begin errors++; $error("FAIL kx_stable: observed %0d drops expected 0", stab_err); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
